dsp48a1_mac_ctrl: RTL
=====================

DSP48A1_MAC_CTRL -- requirements
Module: dsp48a1_mac_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_2, default 18: A/B operand width.
REQ-002 SHALL have parameter WIDTH_4, default 48: P/accumulator width.
REQ-003 SHALL have parameter CNT_W, default 16: beat counter width.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 Ports, in this order:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  operand beat valid
- IN_READY  out  1  controller accepts beat
- IN_A  in  WIDTH_2  multiplicand
- IN_B  in  WIDTH_2  multiplier
- IN_LAST  in  1  final beat of frame
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  result consumed
- OUT_P  out  WIDTH_4  accumulated sum
- OUT_CNT  out  CNT_W  beats in frame
- DSP_A  out  WIDTH_2  to slice A
- DSP_B  out  WIDTH_2  to slice B
- DSP_OPMODE  out  8  to slice OPMODE
- DSP_CEA  out  1  to slice CEA
- DSP_CEB  out  1  to slice CEB
- DSP_CEM  out  1  to slice CEM
- DSP_CEOPMODE  out  1  to slice CEOPMODE
- DSP_CEP  out  1  to slice CEP
- DSP_P  in  WIDTH_4  from slice P

Function
REQ-006 SHALL drive a slice configured A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1, B_INPUT="DIRECT"; a frame computes OUT_P = sum(IN_A*IN_B) mod 2^WIDTH_4, unsigned.
REQ-007 Beat accepted at edge E0 iff IN_VALID&IN_READY.
REQ-008 E0->E1: DSP_A/DSP_B = beat, DSP_CEA=DSP_CEB=1; otherwise all CE=0 and DSP_A/DSP_B hold.
REQ-009 E1->E2: DSP_CEM=1, DSP_CEOPMODE=1, DSP_OPMODE=8'h01 (X=M, Z=0) for first beat of frame, 8'h09 (X=M, Z=P) otherwise.
REQ-010 E2->E3: DSP_CEP=1; CE outputs for stage n SHALL be 0 in bubble cycles so gaps never corrupt the accumulator.
REQ-011 Stage tracking SHALL be a 3-deep token pipe {valid, first, last}.
REQ-012 States: IDLE (no beat in frame), ACCUM (beats accepted, no LAST), DRAIN (LAST accepted, awaiting P), HOLD (OUT_VALID high).
REQ-013 IDLE->ACCUM on non-last accept; IDLE/ACCUM->DRAIN on LAST accept; DRAIN->HOLD when last token leaves stage 3; HOLD->IDLE on OUT_VALID&OUT_READY.
REQ-014 IN_READY=1 in IDLE and ACCUM only; 0 in DRAIN and HOLD.
REQ-015 On LAST beat accepted at E0, OUT_P loads DSP_P at E4 and OUT_VALID is high from E4 (latency 4).
REQ-016 In HOLD, OUT_P and OUT_CNT SHALL stay stable until the handshake; next frame beat is acceptable in the cycle after the handshake.
REQ-017 A single-beat frame (first and last) SHALL use OPMODE 8'h01.
REQ-018 OUT_CNT SHALL count accepted beats per frame, saturating at 2^CNT_W-1, and clear on the first beat of the next frame.

Reset
REQ-019 RST_N low SHALL immediately force IDLE, IN_READY=0, OUT_VALID=0, all DSP_CE*=0, token pipe cleared, OUT_P=0, OUT_CNT=0, DSP_A=DSP_B=0, DSP_OPMODE=0.
REQ-020 IN_READY SHALL rise on the first edge after RST_N deassertion.
REQ-021 Reset mid-frame SHALL discard the partial frame; slice resets are not driven, since the first-beat OPMODE 8'h01 re-seeds P.

Structure
REQ-022 Shared package SHALL hold OPMODE constants (8'h01, 8'h09), the state encoding and default widths.
REQ-023 The token pipe SHALL be one sub-module, dsp48a1_mac_token_pipe.

Verification
REQ-024 Single beat A=3, B=5, LAST -> OUT_P=15, OUT_CNT=1, OUT_VALID 4 cycles after accept.
REQ-025 Back-to-back beats (1,2),(3,4),(5,6),(7,8 LAST) -> OUT_P=100, OUT_CNT=4.
REQ-026 Same frame with 2-cycle IN_VALID gaps -> OUT_P=100; all DSP_CE*=0 in gap stages.
REQ-027 OUT_READY low 5 cycles in HOLD -> OUT_P stable and IN_READY=0; then frame (2,2 LAST) -> OUT_P=4.
REQ-028 Two beats A=B=18'h3FFFF -> OUT_P=48'h1FFFF00002.
REQ-029 RST_N pulse after 2 beats of a frame -> outputs at reset values; then (1,1 LAST) -> OUT_P=1, OUT_CNT=1.

Source files
------------

// File: rtl/dsp48a1_mac_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate controller.
// Holds the OPMODE encodings, the FSM state encoding, the token layout and the default widths.
package dsp48a1_mac_pkg;

    localparam int DEF_WIDTH_2 = 18;
    localparam int DEF_WIDTH_4 = 48;
    localparam int DEF_CNT_W   = 16;

    // X=M, Z=0 seeds the accumulator; X=M, Z=P accumulates onto it
    localparam logic [7:0] OPMODE_MUL = 8'h01;
    localparam logic [7:0] OPMODE_MAC = 8'h09;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tok_t;

endpackage

// File: rtl/dsp48a1_mac_token_pipe.sv
// Three-stage token pipe tracking each beat through the slice's A/B, M/OPMODE and P registers.
// Latency: one cycle per stage; no backpressure, bubbles travel as invalid tokens.
module dsp48a1_mac_token_pipe
    import dsp48a1_mac_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  tok_t tok_i,
    output logic s1_vld_o,
    output logic s2_vld_o,
    output logic s2_first_o,
    output logic s3_vld_o,
    output logic s3_last_o
);

    tok_t s1_q;
    tok_t s2_q;
    // The first flag has no consumer once OPMODE has been issued, so stage 3 drops it
    logic s3_vld_q;
    logic s3_last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_vld_q  <= 1'b0;
            s3_last_q <= 1'b0;
        end else begin
            s1_q      <= tok_i;
            s2_q      <= s1_q;
            s3_vld_q  <= s2_q.vld;
            s3_last_q <= s2_q.last;
        end
    end

    assign s1_vld_o   = s1_q.vld;
    assign s2_vld_o   = s2_q.vld;
    assign s2_first_o = s2_q.first;
    assign s3_vld_o   = s3_vld_q;
    assign s3_last_o  = s3_last_q;

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// Frame controller for a DSP48A1 slice computing sum(A*B) mod 2^WIDTH_4 per frame.
// Result valid 4 cycles after the LAST beat; input stalls from LAST until the result is consumed.
module dsp48a1_mac_ctrl
    import dsp48a1_mac_pkg::*;
#(
    parameter int WIDTH_2 = DEF_WIDTH_2,
    parameter int WIDTH_4 = DEF_WIDTH_4,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH_2-1:0] IN_A,
    input  logic [WIDTH_2-1:0] IN_B,
    input  logic               IN_LAST,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH_4-1:0] OUT_P,
    output logic [CNT_W-1:0]   OUT_CNT,
    output logic [WIDTH_2-1:0] DSP_A,
    output logic [WIDTH_2-1:0] DSP_B,
    output logic [7:0]         DSP_OPMODE,
    output logic               DSP_CEA,
    output logic               DSP_CEB,
    output logic               DSP_CEM,
    output logic               DSP_CEOPMODE,
    output logic               DSP_CEP,
    input  logic [WIDTH_4-1:0] DSP_P
);

    state_e             state_q, state_d;
    logic               rdy_en_q;
    logic               p_ld_q;
    logic [WIDTH_2-1:0] a_q, b_q;
    logic [WIDTH_4-1:0] p_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic in_rdy, accept, is_first;
    logic s1_vld, s2_vld, s2_first, s3_vld, s3_last;
    tok_t tok;

    // rdy_en_q keeps IN_READY low until the first edge after reset release
    assign in_rdy   = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
    assign accept   = IN_VALID && in_rdy;
    assign is_first = (state_q == ST_IDLE);
    assign tok      = '{vld: accept, first: is_first, last: IN_LAST};

    dsp48a1_mac_token_pipe u_pipe (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .tok_i      (tok),
        .s1_vld_o   (s1_vld),
        .s2_vld_o   (s2_vld),
        .s2_first_o (s2_first),
        .s3_vld_o   (s3_vld),
        .s3_last_o  (s3_last)
    );

    always_comb begin
        state_d   = state_q;
        OUT_VALID = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = IN_LAST ? ST_DRAIN : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (accept && IN_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (p_ld_q) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (is_first)          cnt_d = CNT_W'(1);
            else if (cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // P is written at the edge the last token leaves stage 3, so it is captured one edge later
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            rdy_en_q <= 1'b0;
            p_ld_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            p_ld_q   <= s3_vld && s3_last;
            cnt_q    <= cnt_d;
            if (accept) begin
                a_q <= IN_A;
                b_q <= IN_B;
            end
            if (p_ld_q) p_q <= DSP_P;
        end
    end

    assign IN_READY     = in_rdy;
    assign OUT_P        = p_q;
    assign OUT_CNT      = cnt_q;
    assign DSP_A        = a_q;
    assign DSP_B        = b_q;
    assign DSP_CEA      = s1_vld;
    assign DSP_CEB      = s1_vld;
    assign DSP_CEM      = s2_vld;
    assign DSP_CEOPMODE = s2_vld;
    assign DSP_CEP      = s3_vld;
    assign DSP_OPMODE   = s2_vld ? (s2_first ? OPMODE_MUL : OPMODE_MAC) : 8'h00;

endmodule
